// File: rtl/keypad_multitap.sv
// 3x4 keypad scanner with sweep debouncer and phone-style multi-tap letter entry.
// Optional macro KEYPAD_TIMEOUT_EN restarts the tap cycle after TAP_TIMEOUT idle clocks.
module keypad_multitap #(
   parameter int SCAN_CYCLES     = 4,
   parameter int DEBOUNCE_SWEEPS = 2,
   parameter int TAP_TIMEOUT     = 50
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [7:0] letter,
   output logic       letter_valid,
   output logic       letter_strobe,
   output logic       word_strobe,
   output logic       error
);
   localparam int SCW = $clog2(SCAN_CYCLES + 1);
   localparam int DBW = $clog2(DEBOUNCE_SWEEPS + 1);
   localparam logic [3:0] NO_KEY = 4'hF;
   localparam logic [3:0] K_SUBL = 4'd9;
   localparam logic [3:0] K_CLR  = 4'd10;
   localparam logic [3:0] K_SUBW = 4'd11;

   typedef enum logic {IDLE, PENDING} state_t;

   // ---------------- column scanner ----------------
   logic [1:0]     col_idx;
   logic [SCW-1:0] scan_cnt;
   logic [1:0]     acc_hits;   // saturates at 2: anything above one key is no-key
   logic [3:0]     acc_code;
   logic           sample, sweep_end;
   logic [2:0]     row_hits, tot_hits;
   logic [1:0]     row_r, hits_nxt;
   logic [3:0]     code_nxt, sweep_code;

   assign sample    = (scan_cnt == SCW'(SCAN_CYCLES - 1));
   assign sweep_end = sample && (col_idx == 2'd2);
   assign col       = 4'b1000 >> col_idx;

   always_comb begin
      row_hits = 3'(row[0]) + 3'(row[1]) + 3'(row[2]) + 3'(row[3]);
      tot_hits = {1'b0, acc_hits} + row_hits;
      hits_nxt = (tot_hits > 3'd2) ? 2'd2 : tot_hits[1:0];
      if (row[3])      row_r = 2'd0;
      else if (row[2]) row_r = 2'd1;
      else if (row[1]) row_r = 2'd2;
      else             row_r = 2'd3;
      code_nxt   = (row_hits == 3'd1) ? ({2'b0, row_r} * 4'd3 + {2'b0, col_idx}) : acc_code;
      sweep_code = (hits_nxt == 2'd1) ? code_nxt : NO_KEY;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         col_idx  <= '0;
         scan_cnt <= '0;
         acc_hits <= '0;
         acc_code <= '0;
      end else begin
         scan_cnt <= sample ? '0 : scan_cnt + 1'b1;
         if (sweep_end) begin
            col_idx  <= '0;
            acc_hits <= '0;
            acc_code <= '0;
         end else if (sample) begin
            col_idx  <= col_idx + 1'b1;
            acc_hits <= hits_nxt;
            acc_code <= code_nxt;
         end
      end
   end

   // ---------------- sweep debouncer ----------------
   logic [3:0]     db_code;
   logic [DBW-1:0] db_cnt, run_nxt;
   logic           released, press;

   always_comb begin
      if (sweep_code != db_code)                  run_nxt = DBW'(1);
      else if (db_cnt == DBW'(DEBOUNCE_SWEEPS))   run_nxt = db_cnt;
      else                                        run_nxt = db_cnt + 1'b1;
   end

   assign press = sweep_end && released && (sweep_code != NO_KEY) &&
                  (run_nxt == DBW'(DEBOUNCE_SWEEPS));

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         db_code  <= NO_KEY;
         db_cnt   <= '0;
         released <= 1'b1;
      end else if (sweep_end) begin
         db_code <= sweep_code;
         db_cnt  <= run_nxt;
         if (press)
            released <= 1'b0;
         else if (sweep_code == NO_KEY && run_nxt == DBW'(DEBOUNCE_SWEEPS))
            released <= 1'b1;
      end
   end

   // ---------------- tap window ----------------
   logic timed_out;
`ifdef KEYPAD_TIMEOUT_EN
   localparam int TW = $clog2(TAP_TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;
   // tmo_cnt >= TAP_TIMEOUT means strictly more than TAP_TIMEOUT clocks since the last press
   assign timed_out = (tmo_cnt >= TW'(TAP_TIMEOUT));
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst)           tmo_cnt <= '0;
      else if (press)      tmo_cnt <= '0;
      else if (!timed_out) tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign timed_out = (TAP_TIMEOUT < 0);  // window never expires
`endif

   // ---------------- multi-tap FSM ----------------
   function automatic logic [7:0] ascii(input logic [3:0] k, input logic [1:0] t);
      logic [7:0] base;
      case (k)
         4'd1:    base = 8'h41;
         4'd2:    base = 8'h44;
         4'd3:    base = 8'h47;
         4'd4:    base = 8'h4A;
         4'd5:    base = 8'h4D;
         4'd6:    base = 8'h50;
         4'd7:    base = 8'h54;
         default: base = 8'h57;
      endcase
      return base + {6'b0, t};
   endfunction

   state_t     state, state_n;
   logic [3:0] key_q, key_n;
   logic [1:0] tap_q, tap_n, tap_last;
   logic       lstr_n, wstr_n, err_n;
   logic [7:0] letter_n;

   assign tap_last = (key_q == 4'd6 || key_q == 4'd8) ? 2'd3 : 2'd2;

   always_comb begin
      state_n = state;
      key_n   = key_q;
      tap_n   = tap_q;
      lstr_n  = 1'b0;
      wstr_n  = 1'b0;
      err_n   = 1'b0;
      if (press) begin
         if (sweep_code >= 4'd1 && sweep_code <= 4'd8) begin
            if (state == PENDING && sweep_code == key_q && !timed_out) begin
               tap_n = (tap_q == tap_last) ? 2'd0 : tap_q + 2'd1;
            end else begin
               state_n = PENDING;
               key_n   = sweep_code;
               tap_n   = 2'd0;
            end
         end else if (sweep_code == K_SUBL) begin
            if (state == PENDING) begin
               lstr_n  = 1'b1;
               state_n = IDLE;
            end else begin
               err_n = 1'b1;
            end
         end else if (sweep_code == K_CLR) begin
            state_n = IDLE;
         end else if (sweep_code == K_SUBW) begin
            wstr_n  = 1'b1;
            state_n = IDLE;
         end
      end
      // on commit the strobe cycle still shows the letter being committed
      if (lstr_n)                 letter_n = ascii(key_q, tap_q);
      else if (state_n == PENDING) letter_n = ascii(key_n, tap_n);
      else                        letter_n = 8'h00;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state         <= IDLE;
         key_q         <= '0;
         tap_q         <= '0;
         letter        <= '0;
         letter_valid  <= 1'b0;
         letter_strobe <= 1'b0;
         word_strobe   <= 1'b0;
         error         <= 1'b0;
      end else begin
         state         <= state_n;
         key_q         <= key_n;
         tap_q         <= tap_n;
         letter        <= letter_n;
         letter_valid  <= (state_n == PENDING);
         letter_strobe <= lstr_n;
         word_strobe   <= wstr_n;
         error         <= err_n;
      end
   end
endmodule

// File: doc/keypad_multitap.md
KEYPAD_MULTITAP -- requirements
Module: keypad_multitap

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 4: clocks each column is driven before its rows are sampled.
REQ-002 SHALL have parameter DEBOUNCE_SWEEPS, default 2: consecutive identical full sweeps needed to accept a press or a release.
REQ-003 SHALL have parameter TAP_TIMEOUT, default 50: multi-tap window in clocks; used only with KEYPAD_TIMEOUT_EN.
REQ-004 SHALL have ports: clk  input  1  system clock, rising edge.
REQ-005 nRst  input  1  reset, asynchronous, active-low.
REQ-006 row  input  4  keypad rows, active-high; row[3]=R0 … row[0]=R3.
REQ-007 col  output  4  one-hot column drive; col[3]=C0, col[2]=C1, col[1]=C2; col[0] always 0.
REQ-008 letter  output  8  ASCII of the pending letter; 8'h00 when none is pending.
REQ-009 letter_valid  output  1  high while a letter is pending.
REQ-010 letter_strobe  output  1  one-cycle pulse; letter is committed.
REQ-011 word_strobe  output  1  one-cycle pulse; word submit.
REQ-012 error  output  1  one-cycle pulse; illegal action.

Function
REQ-013 Scanner SHALL drive C0, C1, C2 in turn, each for SCAN_CYCLES clocks, and sample row on the last clock of each column.
REQ-014 A sweep SHALL yield one key code when exactly one row bit is set in exactly one column; otherwise it SHALL yield no-key, and multi-key SHALL count as no-key.
REQ-015 Key map: R0C1 ABC, R0C2 DEF, R1C0 GHI, R1C1 JKL, R1C2 MNO, R2C0 PQRS, R2C1 TUV, R2C2 WXYZ, R3C0 submit-letter, R3C1 clear, R3C2 submit-word; R0C0 SHALL be ignored.
REQ-016 A press event SHALL fire once, at the end of the DEBOUNCE_SWEEPS-th consecutive sweep with the same key code, and only if the debouncer is in released state.
REQ-017 Released state SHALL be re-entered after DEBOUNCE_SWEEPS consecutive no-key sweeps; holding a key SHALL never produce a second event.
REQ-018 FSM states: IDLE (nothing pending) and PENDING (key K, tap index T).
REQ-019 Letter key in IDLE -> PENDING, K=key, T=0.
REQ-020 Same letter key in PENDING -> T advances modulo the key's letter count (3, or 4 for PQRS/WXYZ), wrapping to the first letter.
REQ-021 Different letter key in PENDING -> K=new key, T=0; the old letter SHALL be discarded without a strobe.
REQ-022 Submit-letter in PENDING -> letter_strobe for one cycle with letter holding the committed ASCII in that cycle, then IDLE.
REQ-023 Submit-letter in IDLE -> error pulse; state unchanged.
REQ-024 Clear in any state -> IDLE, no strobe.
REQ-025 Submit-word -> word_strobe in any state; a pending letter SHALL be discarded and the FSM SHALL go to IDLE.
REQ-026 letter SHALL be uppercase ASCII ('A'=8'h41) and SHALL update the cycle after the press event.
REQ-027 Outputs SHALL be registered; letter_strobe, word_strobe and error SHALL never be asserted together.

Reset
REQ-028 On nRst low, col SHALL be 4'b1000 and letter, letter_valid, all strobes and error SHALL be 0; FSM SHALL be IDLE, debouncer released, and all counters 0.
REQ-029 Reset mid-press SHALL discard the partial debounce; a key held through reset release SHALL need DEBOUNCE_SWEEPS full sweeps before its press event.

Configuration
REQ-030 With KEYPAD_TIMEOUT_EN defined, a same-key press more than TAP_TIMEOUT clocks after the previous press SHALL restart at T=0, and a pending letter SHALL stay pending.
REQ-031 Without KEYPAD_TIMEOUT_EN, same-key presses SHALL always advance T, and no timeout counter SHALL exist.

Verification
REQ-032 Reset, row=0 for 100 clocks -> col rotates 1000/0100/0010 every 4 clocks; letter=00, no strobes.
REQ-033 R0C1 press, release, then R3C0 press -> letter=8'h41 with letter_valid; then letter_strobe with letter=8'h41; then IDLE.
REQ-034 R2C0 pressed 5 times, then submit -> letter sequence P,Q,R,S,P; strobe with 8'h50.
REQ-035 R3C0 in IDLE -> single error pulse; R0C2 then R3C2 -> word_strobe, no letter_strobe, letter=00.
REQ-036 R0C1 and R1C1 held together -> no event; R0C1 bouncing for 1 sweep only -> no event.
REQ-037 KEYPAD_TIMEOUT_EN: R1C1 twice within 50 clocks -> 'K'; next R1C1 after 60 idle clocks -> 'J'.
